// File: rtl/dbg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbg_pkg: shared encodings for the debug run-control unit                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dbg_pkg;

    localparam int NUM_BP_DEF = 4;
    localparam int CNT_W_DEF  = 32;

    localparam logic [2:0] c_cmd_nop     = 3'd0;
    localparam logic [2:0] c_cmd_halt    = 3'd1;
    localparam logic [2:0] c_cmd_run     = 3'd2;
    localparam logic [2:0] c_cmd_step    = 3'd3;
    localparam logic [2:0] c_cmd_set_bp  = 3'd4;
    localparam logic [2:0] c_cmd_clr_bp  = 3'd5;
    localparam logic [2:0] c_cmd_clr_cnt = 3'd6;

    localparam logic [1:0] c_cause_none = 2'd0;
    localparam logic [1:0] c_cause_halt = 2'd1;
    localparam logic [1:0] c_cause_bp   = 2'd2;
    localparam logic [1:0] c_cause_step = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_STEP    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dbg_bp_match.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbg_bp_match: breakpoint register file, parallel EIP compare, priority   |
// | encoder (lowest matching index wins). Revision: 1.0                      |
// +--------------------------------------------------------------------------+
module dbg_bp_match
    import dbg_pkg::*;
#(
    parameter int NUM_BP = NUM_BP_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_en,
    input  logic        clr_en,
    input  logic [1:0]  idx,
    input  logic [31:0] set_addr,
    input  logic [31:0] eip,
    output logic        hit,
    output logic [1:0]  hit_idx
);

    logic [31:0]       bp_addr_q [NUM_BP];
    logic [31:0]       bp_addr_d [NUM_BP];
    logic [NUM_BP-1:0] bp_valid_q;
    logic [NUM_BP-1:0] bp_valid_d;

    always_comb begin
        bp_addr_d  = bp_addr_q;
        bp_valid_d = bp_valid_q;
        if (set_en) begin
            bp_addr_d[idx]  = set_addr;
            bp_valid_d[idx] = 1'b1;
        end
        if (clr_en) begin
            bp_valid_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_valid_q <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i] <= '0;
            end
        end else begin
            bp_valid_q <= bp_valid_d;
            bp_addr_q  <= bp_addr_d;
        end
    end

    // Scan downward so the lowest matching entry is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid_q[i] && (bp_addr_q[i] == eip)) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbg_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dbg_run_ctrl: debug run control - halt/run/step FSM, breakpoint halts,   |
// | fetch freeze and retired-instruction counter. Revision: 1.0              |
// +--------------------------------------------------------------------------+
module dbg_run_ctrl
    import dbg_pkg::*;
#(
    parameter int NUM_BP = NUM_BP_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             F2D_v,
    input  logic             D2F_stall,
    input  logic             E2W_v,
    input  logic             W2E_stall,
    input  logic [31:0]      E2W_current_eip,
    input  logic             pipe_empty,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [1:0]       cmd_idx,
    input  logic [31:0]      cmd_data,
    output logic             dbg_freeze,
    output logic             dbg_halted,
    output logic [1:0]       halt_cause,
    output logic [1:0]       bp_hit_idx,
    output logic [CNT_W-1:0] retire_count
);

    state_e           state_q, state_d;
    logic             freeze_q, freeze_d;
    logic             halted_q, halted_d;
    logic             ready_q, ready_d;
    logic [1:0]       cause_q, cause_d;
    logic [1:0]       hit_idx_q, hit_idx_d;
    logic             skip_bp_q, skip_bp_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       w_retire;
    logic       w_fetch_fire;
    logic       w_accept;
    logic       w_bp_hit;
    logic [1:0] w_bp_idx;
    logic       w_leave_halted;

    assign w_retire     = E2W_v && !W2E_stall;
    assign w_fetch_fire = F2D_v && !D2F_stall;
    assign w_accept     = cmd_valid && ready_q;

    dbg_bp_match #(
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .clk      (CLK),
        .rst_n    (RST_N),
        .set_en   (w_accept && (cmd_op == c_cmd_set_bp)),
        .clr_en   (w_accept && (cmd_op == c_cmd_clr_bp)),
        .idx      (cmd_idx),
        .set_addr (cmd_data),
        .eip      (E2W_current_eip),
        .hit      (w_bp_hit),
        .hit_idx  (w_bp_idx)
    );

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        hit_idx_d      = hit_idx_q;
        w_leave_halted = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A breakpoint outranks a HALT command landing in the same cycle.
                if (w_retire && !skip_bp_q && w_bp_hit) begin
                    state_d   = ST_HALTING;
                    cause_d   = c_cause_bp;
                    hit_idx_d = w_bp_idx;
                end else if (w_accept && (cmd_op == c_cmd_halt)) begin
                    state_d = ST_HALTING;
                    cause_d = c_cause_halt;
                end
            end
            ST_HALTING: begin
                if (pipe_empty) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (w_accept && (cmd_op == c_cmd_run)) begin
                    state_d        = ST_RUN;
                    cause_d        = c_cause_none;
                    w_leave_halted = 1'b1;
                end else if (w_accept && (cmd_op == c_cmd_step)) begin
                    state_d        = ST_STEP;
                    cause_d        = c_cause_none;
                    w_leave_halted = 1'b1;
                end
            end
            ST_STEP: begin
                if (w_fetch_fire) begin
                    state_d = ST_HALTING;
                    cause_d = c_cause_step;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase

        freeze_d = (state_d == ST_HALTING) || (state_d == ST_HALTED);
        halted_d = (state_d == ST_HALTED);
        ready_d  = (state_d == ST_RUN) || (state_d == ST_HALTED);

        // Resuming from a breakpoint EIP must not re-trigger on that same EIP.
        if (w_leave_halted) begin
            skip_bp_d = 1'b1;
        end else if (w_retire) begin
            skip_bp_d = 1'b0;
        end else begin
            skip_bp_d = skip_bp_q;
        end

        if (w_accept && (cmd_op == c_cmd_clr_cnt)) begin
            count_d = '0;
        end else if (w_retire) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_HALTED;
            freeze_q  <= 1'b1;
            halted_q  <= 1'b1;
            ready_q   <= 1'b1;
            cause_q   <= c_cause_none;
            hit_idx_q <= 2'd0;
            skip_bp_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            freeze_q  <= freeze_d;
            halted_q  <= halted_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
            hit_idx_q <= hit_idx_d;
            skip_bp_q <= skip_bp_d;
            count_q   <= count_d;
        end
    end

    assign cmd_ready    = ready_q;
    assign dbg_freeze   = freeze_q;
    assign dbg_halted   = halted_q;
    assign halt_cause   = cause_q;
    assign bp_hit_idx   = hit_idx_q;
    assign retire_count = count_q;

endmodule
`default_nettype wire
